// File: rtl/five_bit_code_pkg.sv
// five_bit_code_pkg
// Shared constants and types for the ASCII to 5-bit symbol encoder.
//   CODE_W        : symbol code width
//   CODE_*        : punctuation symbol codes 26..31
//   ASCII_*       : ASCII values of the accepted punctuation and letter bounds
//   char_class_t  : classifier result {code, mode, is_letter, is_valid}
package five_bit_code_pkg;

    localparam int CODE_W = 5;

    localparam logic [CODE_W-1:0] CODE_SPACE  = 5'd26;
    localparam logic [CODE_W-1:0] CODE_COMMA  = 5'd27;
    localparam logic [CODE_W-1:0] CODE_PERIOD = 5'd28;
    localparam logic [CODE_W-1:0] CODE_EXCL   = 5'd29;
    localparam logic [CODE_W-1:0] CODE_HYPHEN = 5'd30;
    localparam logic [CODE_W-1:0] CODE_QUEST  = 5'd31;

    localparam logic [7:0] ASCII_SPACE  = 8'h20;
    localparam logic [7:0] ASCII_COMMA  = 8'h2C;
    localparam logic [7:0] ASCII_PERIOD = 8'h2E;
    localparam logic [7:0] ASCII_EXCL   = 8'h21;
    localparam logic [7:0] ASCII_HYPHEN = 8'h2D;
    localparam logic [7:0] ASCII_QUEST  = 8'h3F;

    localparam logic [7:0] ASCII_LOWER_A = 8'h61;
    localparam logic [7:0] ASCII_LOWER_Z = 8'h7A;
    localparam logic [7:0] ASCII_UPPER_A = 8'h41;
    localparam logic [7:0] ASCII_UPPER_Z = 8'h5A;

    typedef struct packed {
        logic [CODE_W-1:0] code;
        logic              mode;       // letter case; meaningless for punctuation
        logic              is_letter;
        logic              is_valid;
    } char_class_t;

endpackage

// File: rtl/ascii_to_five_bit_encoder_if.sv
// ascii_to_five_bit_encoder_if
// Character input and symbol output handshakes of the encoder.
//   in_valid/in_ready/in_char           : character stream into the encoder
//   out_valid/out_ready/out_data/out_mode : symbol stream out of the encoder
// modport slave  : the encoder side
// modport master : the side that feeds characters and consumes symbols
interface ascii_to_five_bit_encoder_if;
    import five_bit_code_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [7:0]        in_char;
    logic              out_valid;
    logic              out_ready;
    logic [CODE_W-1:0] out_data;
    logic              out_mode;

    modport slave (
        input  in_valid, in_char, out_ready,
        output in_ready, out_valid, out_data, out_mode
    );

    modport master (
        output in_valid, in_char, out_ready,
        input  in_ready, out_valid, out_data, out_mode
    );

endinterface

// File: rtl/ascii_char_classify.sv
// ascii_char_classify
// Purely combinational classification of one ASCII character.
//   in_char : ASCII character
//   cls     : code, letter case, letter flag and validity of in_char
module ascii_char_classify
    import five_bit_code_pkg::*;
(
    input  logic [7:0]  in_char,
    output char_class_t cls
);

    always_comb begin
        cls = '0;
        if (in_char >= ASCII_LOWER_A && in_char <= ASCII_LOWER_Z) begin
            cls.code      = CODE_W'(in_char - ASCII_LOWER_A);
            cls.mode      = 1'b0;
            cls.is_letter = 1'b1;
            cls.is_valid  = 1'b1;
        end else if (in_char >= ASCII_UPPER_A && in_char <= ASCII_UPPER_Z) begin
            cls.code      = CODE_W'(in_char - ASCII_UPPER_A);
            cls.mode      = 1'b1;
            cls.is_letter = 1'b1;
            cls.is_valid  = 1'b1;
        end else begin
            case (in_char)
                ASCII_SPACE:  begin cls.code = CODE_SPACE;  cls.is_valid = 1'b1; end
                ASCII_COMMA:  begin cls.code = CODE_COMMA;  cls.is_valid = 1'b1; end
                ASCII_PERIOD: begin cls.code = CODE_PERIOD; cls.is_valid = 1'b1; end
                ASCII_EXCL:   begin cls.code = CODE_EXCL;   cls.is_valid = 1'b1; end
                ASCII_HYPHEN: begin cls.code = CODE_HYPHEN; cls.is_valid = 1'b1; end
                ASCII_QUEST:  begin cls.code = CODE_QUEST;  cls.is_valid = 1'b1; end
                default:      cls = '0;
            endcase
        end
    end

endmodule

// File: rtl/ascii_to_five_bit_encoder.sv
// ascii_to_five_bit_encoder
// Converts ASCII characters into 5-bit symbols plus a case-mode bit, with a
// one-deep registered output stage.
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset
//   bus       : character in / symbol out handshakes (slave side)
//   mode_clr  : force the sticky case mode back to lowercase
//   err       : one-cycle pulse, the character accepted last cycle was invalid
//   err_count : saturating count of rejected characters
//   sym_count : wrapping count of delivered symbols
module ascii_to_five_bit_encoder
    import five_bit_code_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    ascii_to_five_bit_encoder_if.slave  bus,
    input  logic                        mode_clr,
    output logic                        err,
    output logic [CNT_W-1:0]            err_count,
    output logic [CNT_W-1:0]            sym_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    char_class_t       cls;
    logic              in_ready;
    logic              in_fire;
    logic              out_fire;
    logic              accept_sym;
    logic              accept_bad;
    logic              sym_mode;
    logic              sticky_mode;
    logic              out_valid_q;
    logic [CODE_W-1:0] out_data_q;
    logic              out_mode_q;

    ascii_char_classify u_classify (
        .in_char (bus.in_char),
        .cls     (cls)
    );

    // Output stage can take a new symbol when empty or being drained this cycle.
    assign in_ready   = !out_valid_q || bus.out_ready;
    assign in_fire    = bus.in_valid && in_ready;
    assign out_fire   = out_valid_q && bus.out_ready;
    assign accept_sym = in_fire && cls.is_valid;
    assign accept_bad = in_fire && !cls.is_valid;

    // Punctuation takes the mode held before any same-cycle mode_clr.
    assign sym_mode = cls.is_letter ? cls.mode : sticky_mode;

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_mode  = out_mode_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_mode_q  <= 1'b0;
            sticky_mode <= 1'b0;
            err         <= 1'b0;
            err_count   <= '0;
            sym_count   <= '0;
        end else begin
            if (accept_sym) begin
                out_valid_q <= 1'b1;
                out_data_q  <= cls.code;
                out_mode_q  <= sym_mode;
            end else if (out_fire) begin
                out_valid_q <= 1'b0;
            end

            // An accepted letter's case beats a concurrent mode_clr.
            if (accept_sym && cls.is_letter) begin
                sticky_mode <= cls.mode;
            end else if (mode_clr) begin
                sticky_mode <= 1'b0;
            end

            err <= accept_bad;
            if (accept_bad && (err_count != '1)) begin
                err_count <= err_count + CNT_ONE;
            end
            if (out_fire) begin
                sym_count <= sym_count + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_ascii_to_five_bit_encoder.sv
// tb_ascii_to_five_bit_encoder
// Directed sequences plus randomized traffic against a scoreboard model of
// the encoder. The DUT runs with 4-bit counters so saturation and wrap occur.
module tb_ascii_to_five_bit_encoder;
    import five_bit_code_pkg::*;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             mode_clr;
    logic             err;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] sym_count;

    ascii_to_five_bit_encoder_if bus ();

    ascii_to_five_bit_encoder #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .mode_clr  (mode_clr),
        .err       (err),
        .err_count (err_count),
        .sym_count (sym_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Reference model: symbols are kept as code*2+mode.
    int exp_q[$];
    int delivered[$];
    int ref_mode;
    int ref_err_cnt;
    int ref_sym_cnt;
    bit ref_err_next;
    byte unsigned punct[6] = '{8'h20, 8'h2C, 8'h2E, 8'h21, 8'h2D, 8'h3F};

    function automatic bit ref_encode(input int c, input int sticky,
                                      output int code, output int m, output bit letter);
        code = 0; m = sticky; letter = 0;
        if (c >= 8'h61 && c <= 8'h7A) begin
            code = c - 8'h61; m = 0; letter = 1; return 1;
        end
        if (c >= 8'h41 && c <= 8'h5A) begin
            code = c - 8'h41; m = 1; letter = 1; return 1;
        end
        for (int i = 0; i < 6; i++)
            if (c == int'(punct[i])) begin code = 26 + i; return 1; end
        return 0;
    endfunction

    // One clock: drive at negedge, check just after, model the coming edge.
    task automatic cycle(input bit v, input logic [7:0] ch, input bit ordy, input bit clr);
        int code, m;
        bit ok, letter, fire_in, fire_out;
        bus.in_valid = v; bus.in_char = ch; bus.out_ready = ordy; mode_clr = clr;
        #1;
        chk("in_ready", bus.in_ready, (exp_q.size() == 0) || ordy);
        chk("out_valid", bus.out_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
            chk("out_data", bus.out_data, exp_q[0] / 2);
            chk("out_mode", bus.out_mode, exp_q[0] % 2);
        end
        chk("err", err, ref_err_next);
        chk("err_count", err_count, ref_err_cnt);
        chk("sym_count", sym_count, ref_sym_cnt);
        fire_out = (exp_q.size() != 0) && ordy;
        fire_in  = v && ((exp_q.size() == 0) || ordy);
        ref_err_next = 0;
        ok = 0; letter = 0;
        if (fire_out) begin
            delivered.push_back(exp_q.pop_front());
            ref_sym_cnt = (ref_sym_cnt + 1) % (CNT_MAX + 1);
        end
        if (fire_in) begin
            ok = ref_encode(int'(ch), ref_mode, code, m, letter);
            if (ok) exp_q.push_back(code * 2 + m);
            else begin
                ref_err_next = 1;
                if (ref_err_cnt < CNT_MAX) ref_err_cnt++;
            end
        end
        if (fire_in && ok && letter) ref_mode = m;
        else if (clr) ref_mode = 0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input bit v, input logic [7:0] ch, input bit ordy);
        rst = 1; bus.in_valid = v; bus.in_char = ch; bus.out_ready = ordy; mode_clr = 0;
        @(posedge clk);
        @(negedge clk);
        #1;
        exp_q.delete(); ref_mode = 0; ref_err_cnt = 0; ref_sym_cnt = 0; ref_err_next = 0;
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_out_mode", bus.out_mode, 0);
        chk("rst_err", err, 0);
        chk("rst_err_count", err_count, 0);
        chk("rst_sym_count", sym_count, 0);
        rst = 0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) cycle(1, s[i], 1, 0);
        cycle(0, 8'h00, 1, 0);
    endtask

    initial begin
        rst = 1; mode_clr = 0;
        bus.in_valid = 0; bus.in_char = 0; bus.out_ready = 1;
        @(negedge clk);

        // "aB c"
        do_reset(0, 8'h00, 1);
        delivered.delete();
        send_str("aB c");
        chk("t1_n", delivered.size(), 4);
        chk("t1_s0", delivered[0], 0);
        chk("t1_s1", delivered[1], 3);
        chk("t1_s2", delivered[2], 53);
        chk("t1_s3", delivered[3], 4);
        chk("t1_sym_count", sym_count, 4);

        // "Q?" then mode_clr then "."
        do_reset(0, 8'h00, 1);
        delivered.delete();
        cycle(1, "Q", 1, 0);
        cycle(1, "?", 1, 0);
        cycle(0, 8'h00, 1, 1);
        cycle(1, ".", 1, 0);
        cycle(0, 8'h00, 1, 0);
        chk("t2_n", delivered.size(), 3);
        chk("t2_s0", delivered[0], 33);
        chk("t2_s1", delivered[1], 63);
        chk("t2_s2", delivered[2], 56);

        // invalid characters leave the sticky mode alone
        do_reset(0, 8'h00, 1);
        delivered.delete();
        send_str("A");
        delivered.delete();
        cycle(1, 8'h40, 1, 0);
        cycle(1, 8'h7B, 1, 0);
        chk("t3_n", delivered.size(), 0);
        cycle(1, " ", 1, 0);
        cycle(0, 8'h00, 1, 0);
        chk("t3_err_count", err_count, 2);
        chk("t3_space", delivered[0], 53);

        // backpressure: 'z' held while 'y' waits
        do_reset(0, 8'h00, 1);
        delivered.delete();
        cycle(1, "z", 0, 0);
        for (int i = 0; i < 3; i++) cycle(1, "y", 0, 0);
        cycle(1, "y", 1, 0);
        cycle(0, 8'h00, 1, 0);
        chk("t4_n", delivered.size(), 2);
        chk("t4_z", delivered[0], 50);
        chk("t4_y", delivered[1], 48);

        // counter saturation and wrap
        do_reset(0, 8'h00, 1);
        for (int i = 0; i < 17; i++) cycle(1, 8'h7B, 1, 0);
        cycle(0, 8'h00, 1, 0);
        chk("t5_err_sat", err_count, 15);
        for (int i = 0; i < 17; i++) cycle(1, "a", 1, 0);
        cycle(0, 8'h00, 1, 0);
        chk("t5_sym_wrap", sym_count, 1);

        // reset discards a pending symbol
        do_reset(0, 8'h00, 1);
        cycle(1, "k", 0, 0);
        cycle(0, 8'h00, 0, 0);
        do_reset(1, "m", 0);
        delivered.delete();
        for (int i = 0; i < 3; i++) cycle(0, 8'h00, 1, 0);
        chk("t6_n", delivered.size(), 0);
        chk("t6_sym_count", sym_count, 0);

        // randomized traffic
        do_reset(0, 8'h00, 1);
        for (int i = 0; i < 800; i++) begin
            logic [7:0] ch;
            case ($urandom_range(0, 3))
                0: ch = 8'(8'h61 + $urandom_range(0, 25));
                1: ch = 8'(8'h41 + $urandom_range(0, 25));
                2: ch = punct[$urandom_range(0, 5)];
                default: ch = 8'($urandom_range(0, 255));
            endcase
            cycle($urandom_range(0, 4) != 0, ch, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 9) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
